spi_txn_sequencer: RTL and testbench

//  Transaction sequencer directly upstream of the SPI controller (spi_module, spi_controller=1).

---
 rtl/spi_txn_sequencer_if.sv | 43 ++++
 rtl/spi_txn_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_spi_txn_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_txn_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_txn_sequencer_if
// Description : Handshake bundle between the transaction sequencer and the
//               downstream SPI controller (spi_module).
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_txn_sequencer_if #(
    parameter int WORD_SEND_LEN = 8,
    parameter int WORD_RCV_LEN  = 8
);
    logic                     spi_process_next_word;
    logic [WORD_SEND_LEN-1:0] spi_data_word_send;
    logic [4:0]               spi_num_word_send;
    logic [4:0]               spi_num_word_rcv;
    logic                     spi_ready;
    logic                     spi_word_done;
    logic [WORD_RCV_LEN-1:0]  spi_data_word_rcv;
    logic                     spi_transaction_done;

    modport master (
        output spi_process_next_word,
        output spi_data_word_send,
        output spi_num_word_send,
        output spi_num_word_rcv,
        input  spi_ready,
        input  spi_word_done,
        input  spi_data_word_rcv,
        input  spi_transaction_done
    );

    modport slave (
        input  spi_process_next_word,
        input  spi_data_word_send,
        input  spi_num_word_send,
        input  spi_num_word_rcv,
        output spi_ready,
        output spi_word_done,
        output spi_data_word_rcv,
        output spi_transaction_done
    );
endinterface
`default_nettype wire

// File: rtl/spi_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spi_txn_sequencer
// Description : Buffers host TX words, feeds them to the SPI controller one
//               word per handshake, captures RX words and reports done/error.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_txn_sequencer #(
    parameter int WORD_SEND_LEN  = 8,
    parameter int WORD_RCV_LEN   = 8,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     tx_wr_en,
    input  wire logic [4:0]               tx_wr_addr,
    input  wire logic [WORD_SEND_LEN-1:0] tx_wr_data,
    input  wire logic [4:0]               num_send,
    input  wire logic [4:0]               num_rcv,
    input  wire logic                     start,
    input  wire logic [4:0]               rx_rd_addr,
    output logic      [WORD_RCV_LEN-1:0]  rx_rd_data,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    spi_txn_sequencer_if.master           spi
);

    localparam int              AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              ENTRIES    = 1 << AW;
    localparam int              CW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [5:0]      c_depth    = 6'(DEPTH);
    localparam logic            c_tmo_en   = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0]   c_tmo_last = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_ISSUE       = 2'd1,
        S_WAIT_WORD   = 2'd2,
        S_WAIT_FINISH = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [4:0]               r_tx_idx, w_tx_idx_nxt;
    logic [4:0]               r_rx_idx, w_rx_idx_nxt;
    logic [4:0]               r_num_send, w_num_send_nxt;
    logic [4:0]               r_num_rcv, w_num_rcv_nxt;
    logic                     r_done, w_done_nxt;
    logic                     r_error, w_error_nxt;
    logic                     r_pnw, w_pnw_nxt;
    logic                     w_rx_we;
    logic [WORD_SEND_LEN-1:0] r_data_send;
    logic [WORD_SEND_LEN-1:0] w_tx_word;
    logic [WORD_RCV_LEN-1:0]  r_rx_rd_data;
    logic [WORD_RCV_LEN-1:0]  w_rx_word;
    logic                     r_wd_q;
    logic                     w_word_cpl;
    logic [CW-1:0]            r_tmo_cnt;
    logic                     w_tmo_hit;
    logic                     w_tmo_clr;
    logic [5:0]               w_total;
    logic [5:0]               w_req_total;

    logic [WORD_SEND_LEN-1:0] r_tx_mem [0:ENTRIES-1];
    logic [WORD_RCV_LEN-1:0]  r_rx_mem [0:ENTRIES-1];

    // A word_done level held high across several cycles counts as one completion.
    assign w_word_cpl  = spi.spi_word_done & ~r_wd_q;
    assign w_total     = {1'b0, r_num_send} + {1'b0, r_num_rcv};
    assign w_req_total = {1'b0, num_send} + {1'b0, num_rcv};
    assign w_tmo_hit   = c_tmo_en && (r_tmo_cnt == c_tmo_last);
    assign w_tmo_clr   = (r_state == S_IDLE) || (w_state_nxt != r_state) || w_word_cpl;

    always_comb begin
        w_state_nxt    = r_state;
        w_tx_idx_nxt   = r_tx_idx;
        w_rx_idx_nxt   = r_rx_idx;
        w_num_send_nxt = r_num_send;
        w_num_rcv_nxt  = r_num_rcv;
        w_done_nxt     = 1'b0;
        w_error_nxt    = r_error;
        w_pnw_nxt      = 1'b0;
        w_rx_we        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_num_send_nxt = num_send;
                    w_num_rcv_nxt  = num_rcv;
                    w_tx_idx_nxt   = 5'd0;
                    w_rx_idx_nxt   = 5'd0;
                    w_error_nxt    = 1'b0;
                    if ((w_req_total == 6'd0) || ({1'b0, num_send} > c_depth) ||
                        ({1'b0, num_rcv} > c_depth)) begin
                        w_done_nxt  = 1'b1;
                        w_error_nxt = ({1'b0, num_send} > c_depth) || ({1'b0, num_rcv} > c_depth);
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (spi.spi_ready) begin
                    w_pnw_nxt   = 1'b1;
                    w_state_nxt = S_WAIT_WORD;
                end
            end
            S_WAIT_WORD: begin
                if (w_word_cpl) begin
                    if (r_tx_idx < r_num_send) begin
                        w_tx_idx_nxt = r_tx_idx + 5'd1;
                    end else begin
                        w_rx_we      = 1'b1;
                        w_rx_idx_nxt = r_rx_idx + 5'd1;
                    end
                    if (({1'b0, w_tx_idx_nxt} + {1'b0, w_rx_idx_nxt}) == w_total)
                        w_state_nxt = S_WAIT_FINISH;
                    else
                        w_state_nxt = S_ISSUE;
                end
            end
            default: begin
            end
        endcase

        // Early finish from the controller or a stalled handshake ends any active state.
        if (r_state != S_IDLE) begin
            if (spi.spi_transaction_done) begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
                w_pnw_nxt   = 1'b0;
            end else if (w_tmo_hit && (w_state_nxt == r_state) && !w_word_cpl) begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
                w_error_nxt = 1'b1;
                w_pnw_nxt   = 1'b0;
            end
        end
    end

    assign w_tx_word = ({1'b0, w_tx_idx_nxt} < c_depth) ? r_tx_mem[w_tx_idx_nxt[AW-1:0]] : '0;
    assign w_rx_word = ({1'b0, rx_rd_addr} < c_depth) ? r_rx_mem[rx_rd_addr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_tx_idx     <= 5'd0;
            r_rx_idx     <= 5'd0;
            r_num_send   <= 5'd0;
            r_num_rcv    <= 5'd0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_pnw        <= 1'b0;
            r_data_send  <= '0;
            r_rx_rd_data <= '0;
            r_wd_q       <= 1'b0;
            r_tmo_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_tx_idx     <= w_tx_idx_nxt;
            r_rx_idx     <= w_rx_idx_nxt;
            r_num_send   <= w_num_send_nxt;
            r_num_rcv    <= w_num_rcv_nxt;
            r_done       <= w_done_nxt;
            r_error      <= w_error_nxt;
            r_pnw        <= w_pnw_nxt;
            r_rx_rd_data <= w_rx_word;
            r_wd_q       <= spi.spi_word_done;
            r_tmo_cnt    <= w_tmo_clr ? '0 : r_tmo_cnt + CW'(1);
            if (w_state_nxt != S_IDLE)
                r_data_send <= w_tx_word;
        end
    end

    // Buffers are not reset; TX writes are locked out while a transaction runs.
    always_ff @(posedge clk) begin
        if (rst && tx_wr_en && (r_state == S_IDLE) && ({1'b0, tx_wr_addr} < c_depth))
            r_tx_mem[tx_wr_addr[AW-1:0]] <= tx_wr_data;
        if (rst && w_rx_we)
            r_rx_mem[r_rx_idx[AW-1:0]] <= spi.spi_data_word_rcv;
    end

    assign busy                      = (r_state != S_IDLE);
    assign done                      = r_done;
    assign error                     = r_error;
    assign rx_rd_data                = r_rx_rd_data;
    assign spi.spi_process_next_word = r_pnw;
    assign spi.spi_data_word_send    = r_data_send;
    assign spi.spi_num_word_send     = r_num_send;
    assign spi.spi_num_word_rcv      = r_num_rcv;

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_txn_sequencer
// Description : Scoreboard bench for spi_txn_sequencer with a scripted SPI
//               controller model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_txn_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_wr_en;
    logic [4:0] tx_wr_addr;
    logic [7:0] tx_wr_data;
    logic [4:0] num_send;
    logic [4:0] num_rcv;
    logic       start;
    logic [4:0] rx_rd_addr;
    logic [7:0] rx_rd_data;
    logic       busy;
    logic       done;
    logic       error;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_tx[$];
    logic [7:0] rx_src[$];
    logic [7:0] exp_rx[$];

    spi_txn_sequencer_if #(.WORD_SEND_LEN(8), .WORD_RCV_LEN(8)) spi_bus ();

    spi_txn_sequencer #(
        .WORD_SEND_LEN (8),
        .WORD_RCV_LEN  (8),
        .DEPTH         (16),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_wr_en   (tx_wr_en),
        .tx_wr_addr (tx_wr_addr),
        .tx_wr_data (tx_wr_data),
        .num_send   (num_send),
        .num_rcv    (num_rcv),
        .start      (start),
        .rx_rd_addr (rx_rd_addr),
        .rx_rd_data (rx_rd_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .spi        (spi_bus.master)
    );

    always #5 clk = ~clk;

    task automatic write_tx(input logic [4:0] addr, input logic [7:0] data);
        tx_wr_en = 1'b1; tx_wr_addr = addr; tx_wr_data = data;
        @(negedge clk);
        tx_wr_en = 1'b0;
    endtask

    task automatic start_txn(input logic [4:0] ns, input logic [4:0] nr);
        num_send = ns; num_rcv = nr; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Plays the SPI controller for ns sends then nr receives, then finishes the transaction.
    task automatic serve(input int ns, input int nr);
        logic       got;
        logic [7:0] e;
        int         extra;
        for (int i = 0; i < ns + nr; i++) begin
            got = 1'b0;
            for (int c = 0; c < 50 && !got; c++) begin
                @(negedge clk);
                if (spi_bus.spi_process_next_word) got = 1'b1;
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL pulse_wait word %0d: no process pulse in 50 cycles, required one", i);
                return;
            end
            if (i < ns) begin
                e = exp_tx.pop_front();
                checks++;
                if (spi_bus.spi_data_word_send !== e) begin
                    errors++;
                    $display("FAIL send_word %0d: got %h required %h", i, spi_bus.spi_data_word_send, e);
                end
            end
            @(negedge clk);
            checks++;
            if (spi_bus.spi_process_next_word !== 1'b0) begin
                errors++;
                $display("FAIL pulse_width word %0d: process pulse %b required 0", i, spi_bus.spi_process_next_word);
            end
            if (i >= ns) begin
                e = rx_src.pop_front();
                spi_bus.spi_data_word_rcv = e;
                exp_rx.push_back(e);
            end
            spi_bus.spi_word_done = 1'b1;
            @(negedge clk);
            spi_bus.spi_word_done = 1'b0;
        end
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (spi_bus.spi_process_next_word) extra++;
        end
        checks++;
        if (extra != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_finish: extra pulses %0d busy %b, required 0 and 1", extra, busy);
        end
        spi_bus.spi_transaction_done = 1'b1;
        @(negedge clk);
        spi_bus.spi_transaction_done = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL finish: done %b busy %b error %b, required 1 0 0", done, busy, error);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done %b one cycle later, required 0", done);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; tx_wr_en = 1'b0; tx_wr_addr = '0; tx_wr_data = '0;
        num_send = '0; num_rcv = '0; start = 1'b0; rx_rd_addr = '0;
        spi_bus.spi_ready = 1'b1; spi_bus.spi_word_done = 1'b0;
        spi_bus.spi_data_word_rcv = '0; spi_bus.spi_transaction_done = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, error, spi_bus.spi_process_next_word} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: busy/done/error/pnw %b%b%b%b required 0000",
                     busy, done, error, spi_bus.spi_process_next_word);
        end
        checks++;
        if ({spi_bus.spi_data_word_send, spi_bus.spi_num_word_send, spi_bus.spi_num_word_rcv, rx_rd_data} !== 26'd0) begin
            errors++;
            $display("FAIL reset_data: send %h nsend %0d nrcv %0d rx %h required all 0",
                     spi_bus.spi_data_word_send, spi_bus.spi_num_word_send, spi_bus.spi_num_word_rcv, rx_rd_data);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_send_only;
        write_tx(5'd0, 8'hA5); exp_tx.push_back(8'hA5);
        write_tx(5'd1, 8'h3C); exp_tx.push_back(8'h3C);
        write_tx(5'd2, 8'hFF); exp_tx.push_back(8'hFF);
        start_txn(5'd3, 5'd0);
        serve(3, 0);
    endtask

    task automatic test_send_receive;
        logic [7:0] e;
        write_tx(5'd0, 8'h9F); exp_tx.push_back(8'h9F);
        rx_src.push_back(8'h12); rx_src.push_back(8'h34);
        start_txn(5'd1, 5'd2);
        checks++;
        if (spi_bus.spi_num_word_send !== 5'd1 || spi_bus.spi_num_word_rcv !== 5'd2) begin
            errors++;
            $display("FAIL latched_counts: send %0d rcv %0d required 1 2",
                     spi_bus.spi_num_word_send, spi_bus.spi_num_word_rcv);
        end
        serve(1, 2);
        for (int a = 0; exp_rx.size() > 0; a++) begin
            rx_rd_addr = 5'(a);
            @(negedge clk);
            e = exp_rx.pop_front();
            checks++;
            if (rx_rd_data !== e) begin
                errors++;
                $display("FAIL rx_read addr %0d: got %h required %h", a, rx_rd_data, e);
            end
        end
    endtask

    task automatic test_bad_counts;
        start_txn(5'd0, 5'd0);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0 || spi_bus.spi_process_next_word !== 1'b0) begin
            errors++;
            $display("FAIL zero_counts: done %b error %b busy %b pnw %b required 1 0 0 0",
                     done, error, busy, spi_bus.spi_process_next_word);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_counts_pulse: done %b required 0", done);
        end
        start_txn(5'd20, 5'd0);
        checks++;
        if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL send_over_depth: done %b error %b busy %b required 1 1 0", done, error, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || error !== 1'b1) begin
            errors++;
            $display("FAIL error_sticky: done %b error %b required 0 1", done, error);
        end
        start_txn(5'd0, 5'd17);
        checks++;
        if (done !== 1'b1 || error !== 1'b1) begin
            errors++;
            $display("FAIL rcv_over_depth: done %b error %b required 1 1", done, error);
        end
    endtask

    task automatic test_timeout;
        int cyc;
        int pulses;
        spi_bus.spi_ready = 1'b0;
        start_txn(5'd1, 5'd0);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_start: error %b busy %b required 0 1", error, busy);
        end
        cyc = 1;
        pulses = 0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            if (spi_bus.spi_process_next_word) pulses++;
            if (!done) cyc++;
        end
        checks++;
        if (cyc != 100 || error !== 1'b1 || busy !== 1'b0 || pulses != 0) begin
            errors++;
            $display("FAIL timeout: done at cycle %0d error %b busy %b pulses %0d, required 100 1 0 0",
                     cyc, error, busy, pulses);
        end
        spi_bus.spi_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic got;
        logic [7:0] e;
        write_tx(5'd0, 8'h11); write_tx(5'd1, 8'h22);
        exp_tx.delete();
        start_txn(5'd2, 5'd0);
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (spi_bus.spi_process_next_word) got = 1'b1;
        end
        checks++;
        if (!got || spi_bus.spi_data_word_send !== 8'h11) begin
            errors++;
            $display("FAIL reset_mid_issue: pulse %b word %h required 1 11", got, spi_bus.spi_data_word_send);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || spi_bus.spi_process_next_word !== 1'b0 || spi_bus.spi_num_word_send !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid: busy %b pnw %b nsend %0d required 0 0 0",
                     busy, spi_bus.spi_process_next_word, spi_bus.spi_num_word_send);
        end
        rst = 1'b1;
        @(negedge clk);
        write_tx(5'd0, 8'h44); exp_tx.push_back(8'h44);
        write_tx(5'd1, 8'h55); exp_tx.push_back(8'h55);
        start_txn(5'd2, 5'd0);
        serve(2, 0);
        e = 8'h00;
    endtask

    task automatic test_back_to_back;
        logic got;
        logic [7:0] e;
        int pulses;
        write_tx(5'd0, 8'h01); exp_tx.push_back(8'h01);
        write_tx(5'd1, 8'h02); exp_tx.push_back(8'h02);
        write_tx(5'd2, 8'h03); exp_tx.push_back(8'h03);
        start_txn(5'd3, 5'd0);
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (spi_bus.spi_process_next_word) got = 1'b1;
        end
        e = exp_tx.pop_front();
        checks++;
        if (!got || spi_bus.spi_data_word_send !== e) begin
            errors++;
            $display("FAIL b2b_first: pulse %b word %h required 1 %h", got, spi_bus.spi_data_word_send, e);
        end
        @(negedge clk);
        spi_bus.spi_word_done = 1'b1;
        num_send = 5'd5; start = 1'b1;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (spi_bus.spi_process_next_word) begin
                pulses++;
                e = exp_tx.pop_front();
                checks++;
                if (spi_bus.spi_data_word_send !== e) begin
                    errors++;
                    $display("FAIL b2b_word: got %h required %h", spi_bus.spi_data_word_send, e);
                end
            end
        end
        spi_bus.spi_word_done = 1'b0;
        checks++;
        if (pulses != 1 || spi_bus.spi_num_word_send !== 5'd3 || busy !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL held_word_done: pulses %0d nsend %0d busy %b error %b required 1 3 1 0",
                     pulses, spi_bus.spi_num_word_send, busy, error);
        end
        @(negedge clk);
        spi_bus.spi_word_done = 1'b1;
        @(negedge clk);
        spi_bus.spi_word_done = 1'b0;
        serve(1, 0);
    endtask

    initial begin
        test_reset();
        test_send_only();
        test_send_receive();
        test_bad_counts();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
